// File: rtl/adder_1bit.sv
// ---------------------------------------------------------------------------
// adder_1bit
//
// Purpose:
//   One-bit full adder with two views of its result.
//   - A combinational view (S, Cout) that follows the inputs immediately.
//     It does not depend on the clock, the reset or the enable.
//   - A registered view (S_q, Cout_q, valid_q) that captures the
//     combinational result on a rising clock edge whenever en is high.
//   A saturating counter (carry_cnt) records how many captured results had
//   a carry-out of 1. It sticks at its maximum value instead of wrapping.
//
// Parameters:
//   CNT_W     width of the carry-event counter (legal range 2..16)
//
// Ports:
//   clk       clock; every register updates on its rising edge
//   rst       synchronous active-high reset for all registers
//   A, B      addend bits
//   Cin       carry-in bit
//   en        capture enable for the registered view
//   S         combinational sum bit
//   Cout      combinational carry-out bit
//   S_q       registered sum bit
//   Cout_q    registered carry-out bit
//   valid_q   high once the registered view holds a captured result
//   carry_cnt saturating count of captures whose carry-out was 1
// ---------------------------------------------------------------------------
module adder_1bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  input  logic             en,
  output logic             S,
  output logic             Cout,
  output logic             S_q,
  output logic             Cout_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt
);

  // Largest value the counter can hold. The counter stops here.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The propagate term is computed once. Both the sum and the carry use it.
  logic prop;

  // Full-adder equations. These stay purely combinational so the
  // unregistered outputs settle in the same time step as the inputs.
  // X/Z inputs are not treated specially; they simply propagate.
  always_comb begin
    prop = A ^ B;
    S    = prop ^ Cin;
    Cout = (A & B) | (Cin & prop);
  end

  // Capture registers and carry counter.
  // - Reset is sampled only on the clock edge and takes priority over en.
  //   As a result, a capture requested on a reset edge is discarded.
  // - The counter compares against CNT_MAX before incrementing, so it
  //   never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q       <= 1'b0;
      Cout_q    <= 1'b0;
      valid_q   <= 1'b0;
      carry_cnt <= '0;
    end else if (en) begin
      S_q     <= S;
      Cout_q  <= Cout;
      valid_q <= 1'b1;
      if (Cout && (carry_cnt != CNT_MAX)) begin
        carry_cnt <= carry_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_1bit.sv
// ---------------------------------------------------------------------------
// tb_adder_1bit
//
// Purpose:
//   Directed, self-checking bench for adder_1bit. It uses two instances
//   that share all inputs:
//   - dut uses the default counter width (8).
//   - dut_sat uses a 2-bit counter so that saturation is reached quickly.
//   Every expected value is written out by hand in the tasks below.
// ---------------------------------------------------------------------------
module tb_adder_1bit;

  logic       clk;
  logic       rst;
  logic       A;
  logic       B;
  logic       Cin;
  logic       en;
  logic       S;
  logic       Cout;
  logic       S_q;
  logic       Cout_q;
  logic       valid_q;
  logic [7:0] carry_cnt;

  logic       S2;
  logic       Cout2;
  logic       S_q2;
  logic       Cout_q2;
  logic       valid_q2;
  logic [1:0] carry_cnt2;

  int n_cmp;
  int n_bad;

  adder_1bit #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .en(en),
    .S(S), .Cout(Cout), .S_q(S_q), .Cout_q(Cout_q),
    .valid_q(valid_q), .carry_cnt(carry_cnt)
  );

  adder_1bit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .en(en),
    .S(S2), .Cout(Cout2), .S_q(S_q2), .Cout_q(Cout_q2),
    .valid_q(valid_q2), .carry_cnt(carry_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge. Outputs are sampled at that
  // same point, which keeps both activities away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares all four registered outputs of the default-width instance.
  task automatic chk_regs(input string name, input logic es, input logic ec,
                          input logic ev, input logic [7:0] en_cnt);
    n_cmp++;
    if ({S_q, Cout_q, valid_q, carry_cnt} !== {es, ec, ev, en_cnt}) begin
      n_bad++;
      $display("[TB] FAIL %s: S_q/Cout_q/valid_q/carry_cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               name, S_q, Cout_q, valid_q, carry_cnt, es, ec, ev, en_cnt);
    end
  endtask

  // Compares the combinational sum and carry-out of the default-width instance.
  task automatic chk_comb(input string name, input logic es, input logic ec);
    n_cmp++;
    if ({S, Cout} !== {es, ec}) begin
      n_bad++;
      $display("[TB] FAIL %s: S/Cout got %b/%b expected %b/%b", name, S, Cout, es, ec);
    end
  endtask

  // Sweeps all eight input combinations with en low and checks the
  // combinational outputs against the full-adder truth table.
  task automatic test_comb();
    logic [7:0] tbl_s;
    logic [7:0] tbl_c;
    // Truth table indexed by {Cin,B,A}.
    tbl_s = 8'b1001_0110;
    tbl_c = 8'b1110_1000;
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {Cin, B, A} = 3'(i);
      #1;
      chk_comb($sformatf("comb_%0d", i), tbl_s[i], tbl_c[i]);
      n_cmp++;
      if ({S2, Cout2} !== {tbl_s[i], tbl_c[i]}) begin
        n_bad++;
        $display("[TB] FAIL comb_sat_%0d: S/Cout got %b/%b expected %b/%b",
                 i, S2, Cout2, tbl_s[i], tbl_c[i]);
      end
      #9;
    end
  endtask

  // Holds reset high for two edges with every input at 1. The registers
  // must stay clear while the combinational outputs keep showing 1/1.
  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b1;
    {Cin, B, A} = 3'b111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_regs($sformatf("reset_regs_%0d", i), 1'b0, 1'b0, 1'b0, 8'd0);
      chk_comb($sformatf("reset_comb_%0d", i), 1'b1, 1'b1);
      n_cmp++;
      if ({valid_q2, carry_cnt2} !== 3'b000) begin
        n_bad++;
        $display("[TB] FAIL reset_sat_%0d: valid/cnt got %b/%0d expected 0/0",
                 i, valid_q2, carry_cnt2);
      end
    end
  endtask

  // Performs a capture with a carry, then a capture without a carry.
  // The counter must advance only on the first one.
  task automatic test_capture();
    rst = 1'b0;
    en  = 1'b1;
    {Cin, B, A} = 3'b011;
    tick();
    chk_regs("capture_carry", 1'b0, 1'b1, 1'b1, 8'd1);
    {Cin, B, A} = 3'b001;
    tick();
    chk_regs("capture_nocarry", 1'b1, 1'b0, 1'b1, 8'd1);
  endtask

  // With en low, the registered view must hold its value while the
  // combinational view keeps following the inputs.
  task automatic test_hold();
    logic [2:0] vec [3];
    logic [1:0] exp [3];
    vec[0] = 3'b111; exp[0] = 2'b11;
    vec[1] = 3'b011; exp[1] = 2'b10;
    vec[2] = 3'b110; exp[2] = 2'b10;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {Cin, B, A} = vec[i];
      #1;
      chk_comb($sformatf("hold_comb_%0d", i), exp[i][0], exp[i][1]);
      tick();
      chk_regs($sformatf("hold_regs_%0d", i), 1'b1, 1'b0, 1'b1, 8'd1);
    end
  endtask

  // After a reset, captures 1+1+1 on every edge:
  // - The 2-bit counter must stop at 3.
  // - The 8-bit counter must stop at 255.
  task automatic test_saturation();
    logic [1:0] exp2 [5];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    {Cin, B, A} = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (carry_cnt2 !== exp2[i]) begin
        n_bad++;
        $display("[TB] FAIL sat2_cycle_%0d: carry_cnt got %0d expected %0d",
                 i, carry_cnt2, exp2[i]);
      end
    end
    chk_regs("sat8_mid", 1'b1, 1'b1, 1'b1, 8'd5);
    for (int i = 0; i < 255; i++) tick();
    chk_regs("sat8_top", 1'b1, 1'b1, 1'b1, 8'd255);
    tick();
    chk_regs("sat8_stay", 1'b1, 1'b1, 1'b1, 8'd255);
  endtask

  // Asserts reset on the same edge as a capture that has a carry. The
  // capture must be discarded and every register cleared.
  task automatic test_reset_collision();
    rst = 1'b1;
    en  = 1'b1;
    {Cin, B, A} = 3'b011;
    tick();
    chk_regs("collide_regs", 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++;
    if ({valid_q2, carry_cnt2} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL collide_sat: valid/cnt got %b/%0d expected 0/0",
               valid_q2, carry_cnt2);
    end
    rst = 1'b0;
    en  = 1'b0;
    tick();
    chk_regs("collide_after", 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  // Runs every scenario in order, then prints the single summary line.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    en  = 1'b0;
    A   = 1'b0;
    B   = 1'b0;
    Cin = 1'b0;
    test_comb();
    test_reset();
    test_capture();
    test_hold();
    test_saturation();
    test_reset_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_1bit.md
ADDER_1BIT -- requirements
Module: adder_1bit

Interface
REQ-001 Parameter: CNT_W, default 8, width of the carry-event counter (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: A  input  1  addend bit A.
REQ-005 Port: B  input  1  addend bit B.
REQ-006 Port: Cin  input  1  carry-in bit.
REQ-007 Port: en  input  1  capture enable for registered outputs.
REQ-008 Port: S  output  1  combinational sum bit.
REQ-009 Port: Cout  output  1  combinational carry-out bit.
REQ-010 Port: S_q  output  1  registered sum bit.
REQ-011 Port: Cout_q  output  1  registered carry-out bit.
REQ-012 Port: valid_q  output  1  registered outputs hold a captured result.
REQ-013 Port: carry_cnt  output  CNT_W  saturating count of captured results with carry-out = 1.

Function
REQ-014 S SHALL equal A XOR B XOR Cin, purely combinational, with no dependence on clk, rst or en.
REQ-015 Cout SHALL equal (A AND B) OR (Cin AND (A XOR B)), purely combinational.
REQ-016 {Cout,S} SHALL equal the 2-bit arithmetic sum A+B+Cin for all 8 input combinations: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11 (order Cin,B,A -> Cout,S).
REQ-017 S and Cout SHALL settle within the same simulation time step as an input change; zero cycles latency.
REQ-018 S and Cout SHALL be valid with no clock running and regardless of rst.
REQ-019 On a rising clk edge with rst=0 and en=1: S_q<=S, Cout_q<=Cout, valid_q<=1; latency one cycle.
REQ-020 On a rising clk edge with rst=0 and en=0: S_q, Cout_q, valid_q and carry_cnt SHALL hold.
REQ-021 On each capture (REQ-019) with Cout=1, carry_cnt SHALL increment by 1.
REQ-022 carry_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-023 Inputs that are X/Z SHALL NOT be specially handled; outputs follow the logic equations.

Reset
REQ-024 rst is sampled only on the rising clk edge; no asynchronous effect on any register.
REQ-025 On a rising edge with rst=1: S_q=0, Cout_q=0, valid_q=0, carry_cnt=0, overriding en.
REQ-026 Reset asserted mid-operation SHALL clear all registers on that edge and discard the capture in progress.
REQ-027 S and Cout SHALL be unaffected by rst.

Verification
REQ-028 Exhaustive sweep: apply all 8 {Cin,B,A} combinations, 10 ns each, no clock -> S/Cout match REQ-016 table each step.
REQ-029 rst=1 for 2 cycles with A=B=Cin=1, en=1 -> S_q=0, Cout_q=0, valid_q=0, carry_cnt=0; S=1, Cout=1 throughout.
REQ-030 After reset, en=1, A=1,B=1,Cin=0 for 1 cycle -> next cycle S_q=0, Cout_q=1, valid_q=1, carry_cnt=1.
REQ-031 en=0 with inputs changing 3 cycles -> S_q, Cout_q, carry_cnt unchanged; S/Cout track inputs.
REQ-032 CNT_W=2, en=1, A=B=Cin=1 for 5 cycles -> carry_cnt reaches 3 and stays 3.
REQ-033 rst=1 on the same edge as en=1 with Cout=1 -> carry_cnt=0, valid_q=0 after the edge.
